rename_stage_nw: RTL

//  WIDTH-wide register-rename stage between decode and dispatch. Holds the speculative RAT and a

---
 rtl/rename_stage_nw.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/rename_stage_nw.sv
// Rename stage: speculative RAT + circular free list; registered outputs 1 cycle after transfer, held while !i_ready.
// Whole group stalls when free pregs < dests needed. Define RENAME_CKPT_EN for commit tracking and flush recovery.
module rename_stage_nw #(
  parameter int WIDTH     = 2,
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 128,
  parameter int PAYLOAD_W = 64,
  localparam int AW = $clog2(NUM_AREGS),
  localparam int PW = $clog2(NUM_PREGS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH*AW-1:0]        i_src0,
  input  logic [WIDTH*AW-1:0]        i_src1,
  input  logic [WIDTH*AW-1:0]        i_dst,
  input  logic [WIDTH*PAYLOAD_W-1:0] i_payload,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH*PW-1:0]        o_psrc0,
  output logic [WIDTH*PW-1:0]        o_psrc1,
  output logic [WIDTH*PW-1:0]        o_pdst,
  output logic [WIDTH*PW-1:0]        o_old_pdst,
  output logic [WIDTH*PAYLOAD_W-1:0] o_payload,
  input  logic [WIDTH-1:0]           i_free_valid,
  input  logic [WIDTH*PW-1:0]        i_free_preg,
`ifdef RENAME_CKPT_EN
  input  logic [WIDTH-1:0]           i_commit_valid,
  input  logic [WIDTH*AW-1:0]        i_commit_areg,
  input  logic [WIDTH*PW-1:0]        i_commit_preg,
  input  logic                       i_flush,
`endif
  output logic [PW:0]                o_free_count
);
  localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int FLW = $clog2(FL_DEPTH);
  localparam logic [FLW:0] FL_DEPTH_W = (FLW+1)'(FL_DEPTH);

  function automatic logic [FLW-1:0] fl_add(input logic [FLW-1:0] base, input logic [2:0] ofs);
    logic [FLW:0] s;
    s = {1'b0, base} + (FLW+1)'(ofs);
    if (s >= FL_DEPTH_W) s = s - FL_DEPTH_W;
    return s[FLW-1:0];
  endfunction

  logic [PW-1:0]              rat_q [NUM_AREGS];
  logic [PW-1:0]              fl_q  [FL_DEPTH];
  logic [FLW-1:0]             head_q, head_d, tail_q, tail_d;
  logic [PW:0]                count_q, count_d;
  logic                       valid_q;
  logic [WIDTH*PW-1:0]        psrc0_q, psrc1_q, pdst_q, old_pdst_q;
  logic [WIDTH*PW-1:0]        psrc0_d, psrc1_d, pdst_d, old_pdst_d;
  logic [WIDTH*PAYLOAD_W-1:0] payload_q;
  logic [PW-1:0]              pdst_c   [WIDTH];
  logic [FLW-1:0]             push_idx [WIDTH];
  logic [WIDTH-1:0]           push_en;
  logic [2:0]                 pop_n, push_n;
  logic                       xfer, flush;

  // Slot k takes the next free entry past those taken by older slots; sources/old mapping bypass from older slots.
  always_comb begin
    logic [AW-1:0] s0, s1, dk, dj;
    logic [PW-1:0] p0v, p1v, ov;
    pop_n = '0;
    for (int k = 0; k < WIDTH; k++) begin
      dk = i_dst[k*AW +: AW];
      pdst_c[k] = '0;
      if (dk != '0) begin
        pdst_c[k] = fl_q[fl_add(head_q, pop_n)];
        pop_n = pop_n + 3'd1;
      end
    end
    psrc0_d = '0;
    psrc1_d = '0;
    pdst_d = '0;
    old_pdst_d = '0;
    for (int k = 0; k < WIDTH; k++) begin
      s0 = i_src0[k*AW +: AW];
      s1 = i_src1[k*AW +: AW];
      dk = i_dst[k*AW +: AW];
      p0v = rat_q[s0];
      p1v = rat_q[s1];
      ov = rat_q[dk];
      for (int j = 0; j < k; j++) begin
        dj = i_dst[j*AW +: AW];
        if (dj != '0 && dj == s0) p0v = pdst_c[j];
        if (dj != '0 && dj == s1) p1v = pdst_c[j];
        if (dj != '0 && dj == dk) ov = pdst_c[j];
      end
      if (s0 == '0) p0v = '0;
      if (s1 == '0) p1v = '0;
      if (dk == '0) ov = '0;
      psrc0_d[k*PW +: PW] = p0v;
      psrc1_d[k*PW +: PW] = p1v;
      old_pdst_d[k*PW +: PW] = ov;
      pdst_d[k*PW +: PW] = pdst_c[k];
    end
  end

  always_comb begin
    push_n = '0;
    for (int k = 0; k < WIDTH; k++) begin
      push_en[k] = i_free_valid[k] && (i_free_preg[k*PW +: PW] != '0);
      push_idx[k] = fl_add(tail_q, push_n);
      if (push_en[k]) push_n = push_n + 3'd1;
    end
  end

`ifdef RENAME_CKPT_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  assign o_ready = ~flush & (~valid_q | i_ready) & (count_q >= (PW+1)'(pop_n));
  assign xfer    = i_valid & o_ready;
  assign head_d  = fl_add(head_q, xfer ? pop_n : 3'd0);
  assign tail_d  = fl_add(tail_q, push_n);
  assign count_d = count_q - (xfer ? (PW+1)'(pop_n) : '0) + (PW+1)'(push_n);

`ifdef RENAME_CKPT_EN
  logic [PW-1:0]  arch_q [NUM_AREGS];
  logic [PW-1:0]  arch_d [NUM_AREGS];
  logic [FLW-1:0] chead_q, chead_d;
  logic [PW:0]    recov_n;

  always_comb begin
    logic [AW-1:0] a;
    logic [2:0]    n;
    arch_d = arch_q;
    n = '0;
    for (int k = 0; k < WIDTH; k++) begin
      a = i_commit_areg[k*AW +: AW];
      if (i_commit_valid[k] && a != '0) begin
        arch_d[a] = i_commit_preg[k*PW +: PW];
        n = n + 3'd1;
      end
    end
    chead_d = fl_add(chead_q, n);
  end

  // Entries popped speculatively beyond the committed head go back to the free list on flush.
  assign recov_n = (PW+1)'({1'b0, head_q} + ((head_q < chead_d) ? FL_DEPTH_W : '0) - {1'b0, chead_d});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int a = 0; a < NUM_AREGS; a++) arch_q[a] <= PW'(a);
      chead_q <= '0;
    end else begin
      arch_q <= arch_d;
      chead_q <= chead_d;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int a = 0; a < NUM_AREGS; a++) rat_q[a] <= PW'(a);
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= PW'(NUM_AREGS + i);
      head_q <= '0;
      tail_q <= '0;
      count_q <= (PW+1)'(FL_DEPTH);
      valid_q <= 1'b0;
      psrc0_q <= '0;
      psrc1_q <= '0;
      pdst_q <= '0;
      old_pdst_q <= '0;
      payload_q <= '0;
    end else begin
      for (int k = 0; k < WIDTH; k++)
        if (push_en[k]) fl_q[push_idx[k]] <= i_free_preg[k*PW +: PW];
      tail_q <= tail_d;
`ifdef RENAME_CKPT_EN
      if (i_flush) begin
        rat_q <= arch_d;
        head_q <= chead_d;
        count_q <= count_d + recov_n;
      end else
`endif
      begin
        if (xfer)
          for (int k = 0; k < WIDTH; k++)
            if (i_dst[k*AW +: AW] != '0) rat_q[i_dst[k*AW +: AW]] <= pdst_c[k];
        head_q <= head_d;
        count_q <= count_d;
      end
      if (xfer) begin
        valid_q <= 1'b1;
        psrc0_q <= psrc0_d;
        psrc1_q <= psrc1_d;
        pdst_q <= pdst_d;
        old_pdst_q <= old_pdst_d;
        payload_q <= i_payload;
      end else if (i_ready || flush) begin
        valid_q <= 1'b0;
        psrc0_q <= '0;
        psrc1_q <= '0;
        pdst_q <= '0;
        old_pdst_q <= '0;
        payload_q <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)
      assert ((PW+2)'(count_q) + (PW+2)'(push_n) <= (PW+2)'(FL_DEPTH))
        else $error("free list overflow");
  end

  assign o_valid      = valid_q;
  assign o_psrc0      = psrc0_q;
  assign o_psrc1      = psrc1_q;
  assign o_pdst       = pdst_q;
  assign o_old_pdst   = old_pdst_q;
  assign o_payload    = payload_q;
  assign o_free_count = count_q;
endmodule
